stopwatch_counter: RTL
======================

# stopwatch_counter

Four-digit BCD MM:SS timekeeper that consumes the `countup` / `paused` control pair produced by the stopwatch key FSM. It divides the system clock into one-second steps, and counts up or down accordingly or holds. Its digit outputs feed the seven-segment display drivers.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count step (1 s at 50 MHz); legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `countup`  in  1  1 = increment, 0 = decrement; sampled on the stepping edge only.
- `paused`  in  1  1 = freeze prescaler and digits.
- `clear`  in  1  synchronous clear of digits and prescaler.
- `sec_lo`  out  4  seconds units, BCD 0–9.
- `sec_hi`  out  4  seconds tens, BCD 0–5.
- `min_lo`  out  4  minutes units, BCD 0–9.
- `min_hi`  out  4  minutes tens, BCD 0–5.
- `tick`  out  1  one-cycle pulse on every step edge.
- `zero_hit`  out  1  one-cycle pulse when a down-step reaches 00:00.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1.
  - It advances only when `paused`=0 and `clear`=0.
  - While paused it holds its value, so a resumed second completes its remaining cycles.
- Step condition: `paused`=0, `clear`=0, `pre`=TICK_DIV-1. On the step edge:
  - `pre`←0.
  - `tick`←1.
  - Digits update per the current `countup` value.
- Up-step: ripple increment.
  - `sec_lo` 9→0 carries into `sec_hi`.
  - `sec_hi` 5→0 carries into `min_lo`.
  - `min_lo` 9→0 carries into `min_hi`.
  - `min_hi` 5→0 wraps, so 59:59 → 00:00. No flag is raised on wrap.
- Down-step: ripple decrement with borrow.
  - `sec_lo` 0→9, `sec_hi` 0→5, `min_lo` 0→9, `min_hi` 0→5.
  - At 00:00 the down-step saturates: digits stay 00:00, `tick` still pulses, `zero_hit` stays 0.
  - 00:01 → 00:00 asserts `zero_hit` on that same edge.
- `clear`=1 takes priority over stepping and pause:
  - digits←00:00, `pre`←0.
  - `tick`=0 and `zero_hit`=0 on that edge, even if the step condition would have held.
- A direction change between steps is legal. Only the value of `countup` at the step edge matters.
- Digits never hold a non-BCD value or a tens value above 5.

## Timing
- Reset (asynchronous, immediate): all digits 0, `pre`=0, `tick`=0, `zero_hit`=0.
- Reset release takes effect on the next `clk` edge. Reset asserted mid-count discards the partial second.
- All outputs are registered; there is no combinational input→output path.
- Latency: starting from `pre`=0 with `paused`=0, the first step occurs on the TICK_DIV-th rising edge. `tick` and the new digits become visible together after that edge.
- `TICK_DIV`=1: a step occurs on every unpaused, uncleared edge.
- `tick` and `zero_hit` are high for exactly one cycle per event.
- `paused` rising on the would-be step edge suppresses that step; `pre` stays at TICK_DIV-1.

## Structure
- Package `stopwatch_pkg`:
  - `typedef logic [3:0] bcd_t`
  - constants `UNITS_MAX`=9 and `TENS_MAX`=5
- Sub-module `bcd_digit` (one per digit, chained):
  - parameter `MAX`
  - inputs `en`, `up`, `clr`
  - outputs `q`, `cy` (carry/borrow)
  - `cy` is asserted when `en` and (`up` & `q`=MAX or `!up` & `q`=0).
- Top level holds the prescaler and the 00:00 saturation/zero-detect logic. Down-step enables are gated off at 00:00.

## Test plan
1. `TICK_DIV`=4, reset, `countup`=1, `paused`=0 for 40 cycles → display 00:10, exactly 10 `tick` pulses, first pulse on edge 4.
2. `TICK_DIV`=1, count up 3600 steps from 00:00 → passes 00:59→01:00 and 09:59→10:00, ends at 00:00 after 59:59, `zero_hit` never asserted.
3. `TICK_DIV`=1, count up to 01:00, then `countup`=0:
   - next steps give 00:59, …, 00:01, 00:00, with `zero_hit` pulsing once at the 00:01→00:00 edge.
   - 3 more steps → display stays 00:00, 3 `tick` pulses, no `zero_hit`.
4. `TICK_DIV`=4, `paused`=1 after 2 unpaused cycles, held 10 cycles → digits constant, `tick` low. Release → step on the 2nd following edge.
5. `TICK_DIV`=4, `clear` asserted on the edge where `pre`=3 → 00:00, no `tick`, next step 4 edges later. Asynchronous `rst` pulse between edges at 12:34 → outputs read 00:00 before the next `clk` edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD digit type and digit limits for the stopwatch
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t UNITS_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;
endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// bcd_digit: one up/down BCD digit, wraps 0..MAX; ports clk, rst (async), en, up, clr -> q, cy (carry/borrow out)
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = UNITS_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic up,
  input  logic clr,
  output bcd_t q,
  output logic cy
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= up ? (q == MAX ? '0 : q + 4'd1) : (q == '0 ? MAX : q - 4'd1);
  assign cy = en & (up ? q == MAX : q == '0);
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD up/down timekeeper; ports clk, rst (async), countup, paused, clear -> sec_lo, sec_hi, min_lo, min_hi, tick, zero_hit
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic countup,
  input  logic paused,
  input  logic clear,
  output bcd_t sec_lo,
  output bcd_t sec_hi,
  output bcd_t min_lo,
  output bcd_t min_hi,
  output logic tick,
  output logic zero_hit
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic step, is_zero, at_one, unused_wrap;
  logic [3:0] en, cy;
  bcd_t d [4];
  assign step = !paused && !clear && pre == PW'(TICK_DIV - 1);
  assign is_zero = {d[3], d[2], d[1], d[0]} == 16'h0000;
  assign at_one = {d[3], d[2], d[1], d[0]} == 16'h0001;
  // a down-step at 00:00 must not borrow through to 59:59
  assign en = {cy[2:0], step && (countup || !is_zero)};
  assign unused_wrap = cy[3];
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit #(.MAX(i % 2 ? TENS_MAX : UNITS_MAX)) u_dig (
      .clk(clk), .rst(rst), .en(en[i]), .up(countup), .clr(clear), .q(d[i]), .cy(cy[i])
    );
  end
  assign {min_hi, min_lo, sec_hi, sec_lo} = {d[3], d[2], d[1], d[0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      tick <= 1'b0;
      zero_hit <= 1'b0;
    end else begin
      pre <= clear || step ? '0 : paused ? pre : pre + 1'b1;
      tick <= step;
      zero_hit <= step && !countup && at_one;
    end
endmodule
